// File: rtl/countdown_timer_if.sv
// Control and time-field bundle for countdown_timer. The master side
// loads presets and gates counting; the slave side reports the remaining time.
interface countdown_timer_if;
  logic       start_signal;
  logic       load;
  logic [3:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic [9:0] load_milliseconds;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [9:0] milliseconds;
  logic       running;
  logic       expired;
  logic       done;

  modport master (
    output start_signal, load, load_hours, load_minutes, load_seconds, load_milliseconds,
    input  hours, minutes, seconds, milliseconds, running, expired, done
  );

  modport slave (
    input  start_signal, load, load_hours, load_minutes, load_seconds, load_milliseconds,
    output hours, minutes, seconds, milliseconds, running, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// H:M:S.ms countdown timer. It decrements once per TICK_DIV cycles while started
// and latches EXPIRED at zero until the next load or reset.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   tif
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

  localparam logic [15:0] PMAX = 16'(TICK_DIV - 1);

  state_e      state_q, state_d;
  logic [3:0]  hours_q, hours_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [9:0]  ms_q, ms_d;
  logic [15:0] presc_q, presc_d;
  logic        done_q, done_d;

  logic [3:0]  dec_h;
  logic [5:0]  dec_m, dec_s;
  logic [9:0]  dec_ms;
  logic        is_zero, dec_zero, tick;

  assign is_zero = (hours_q == 4'd0) && (min_q == 6'd0) && (sec_q == 6'd0) && (ms_q == 10'd0);
  assign tick    = (presc_q == PMAX);

  // Borrow chain. Callers only use it when the time is non-zero, so hours never wraps.
  always_comb begin
    dec_h  = hours_q;
    dec_m  = min_q;
    dec_s  = sec_q;
    dec_ms = ms_q;
    if (ms_q != 10'd0) begin
      dec_ms = ms_q - 10'd1;
    end else begin
      dec_ms = 10'd999;
      if (sec_q != 6'd0) begin
        dec_s = sec_q - 6'd1;
      end else begin
        dec_s = 6'd59;
        if (min_q != 6'd0) begin
          dec_m = min_q - 6'd1;
        end else begin
          dec_m = 6'd59;
          dec_h = hours_q - 4'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_h == 4'd0) && (dec_m == 6'd0) && (dec_s == 6'd0) && (dec_ms == 10'd0);

  always_comb begin
    state_d = state_q;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tif.start_signal) begin
          if (is_zero) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!tif.start_signal) begin
          // Prescaler is kept so a paused partial tick resumes where it stopped.
          state_d = IDLE;
        end else begin
          presc_d = tick ? 16'd0 : presc_q + 16'd1;
          if (tick && !is_zero) begin
            hours_d = dec_h;
            min_d   = dec_m;
            sec_d   = dec_s;
            ms_d    = dec_ms;
            if (dec_zero) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
      end
      EXPIRED: state_d = EXPIRED;
      default: state_d = IDLE;
    endcase
    // Load overrides any tick or expiry decided above in the same cycle.
    if (tif.load) begin
      state_d = IDLE;
      presc_d = 16'd0;
      done_d  = 1'b0;
      hours_d = tif.load_hours;
      min_d   = (tif.load_minutes > 6'd59) ? 6'd59 : tif.load_minutes;
      sec_d   = (tif.load_seconds > 6'd59) ? 6'd59 : tif.load_seconds;
      ms_d    = (tif.load_milliseconds > 10'd999) ? 10'd999 : tif.load_milliseconds;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hours_q <= 4'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      ms_q    <= 10'd0;
      presc_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hours_q <= hours_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign tif.hours        = hours_q;
  assign tif.minutes      = min_q;
  assign tif.seconds      = sec_q;
  assign tif.milliseconds = ms_q;
  assign tif.running      = (state_q == RUN);
  assign tif.expired      = (state_q == EXPIRED);
  assign tif.done         = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_countdown_timer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  countdown_timer_if ia();
  countdown_timer_if ib();

  countdown_timer #(.TICK_DIV(1)) u_a (.clk(clk), .reset(reset), .tif(ia));
  countdown_timer #(.TICK_DIV(4)) u_b (.clk(clk), .reset(reset), .tif(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tv(int h, int m, int s, int ms);
    return {6'd0, 4'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  function automatic logic [31:0] time_a();
    return {6'd0, ia.hours, ia.minutes, ia.seconds, ia.milliseconds};
  endfunction

  function automatic logic [31:0] time_b();
    return {6'd0, ib.hours, ib.minutes, ib.seconds, ib.milliseconds};
  endfunction

  function automatic logic [31:0] flags_a();
    return {29'd0, ia.running, ia.expired, ia.done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int h, input int m, input int s, input int ms);
    ia.load_hours = 4'(h); ia.load_minutes = 6'(m);
    ia.load_seconds = 6'(s); ia.load_milliseconds = 10'(ms);
    ia.load = 1'b1;
    step(1);
    ia.load = 1'b0;
  endtask

  // flags packed as {running, expired, done}
  initial begin
    checks = 0; failures = 0;
    reset = 1'b0;
    ia.start_signal = 1'b0; ia.load = 1'b0;
    ia.load_hours = '0; ia.load_minutes = '0; ia.load_seconds = '0; ia.load_milliseconds = '0;
    ib.start_signal = 1'b0; ib.load = 1'b0;
    ib.load_hours = '0; ib.load_minutes = '0; ib.load_seconds = '0; ib.load_milliseconds = '0;
    #2;
    chk("reset_time_a", time_a(), tv(0, 0, 0, 0));
    chk("reset_flags_a", flags_a(), 32'd0);
    chk("reset_time_b", time_b(), tv(0, 0, 0, 0));
    step(2);
    reset = 1'b1;
    step(1);

    // borrow chain
    load_a(1, 0, 0, 0);
    chk("load_1h", time_a(), tv(1, 0, 0, 0));
    chk("load_1h_flags", flags_a(), 32'd0);
    ia.start_signal = 1'b1;
    step(1);
    chk("start_running", flags_a(), 32'd4);
    chk("start_no_dec", time_a(), tv(1, 0, 0, 0));
    step(1);
    chk("borrow_first", time_a(), tv(0, 59, 59, 999));
    step(1000);
    chk("borrow_1000", time_a(), tv(0, 59, 58, 999));
    chk("borrow_running", flags_a(), 32'd4);

    // async reset mid-count, start left high
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_time", time_a(), tv(0, 0, 0, 0));
    chk("async_rst_flags", flags_a(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("rst_no_done", flags_a(), 32'd0);
    end
    reset = 1'b1;
    step(1);
    chk("post_rst_expire", flags_a(), 32'd3);
    step(1);
    chk("post_rst_done_drop", flags_a(), 32'd2);
    ia.start_signal = 1'b0;

    // expiry
    load_a(0, 0, 1, 5);
    chk("exp_load_flags", flags_a(), 32'd0);
    ia.start_signal = 1'b1;
    step(1);
    step(1004);
    chk("exp_1004", time_a(), tv(0, 0, 0, 1));
    chk("exp_1004_flags", flags_a(), 32'd4);
    step(1);
    chk("exp_zero", time_a(), tv(0, 0, 0, 0));
    chk("exp_flags", flags_a(), 32'd3);
    step(1);
    chk("exp_done_drop", flags_a(), 32'd2);
    step(5000);
    chk("exp_hold_time", time_a(), tv(0, 0, 0, 0));
    chk("exp_hold_flags", flags_a(), 32'd2);
    ia.start_signal = 1'b0;

    // clamp
    load_a(15, 63, 60, 1023);
    chk("clamp_val", time_a(), tv(15, 59, 59, 999));
    chk("clamp_expired_drop", flags_a(), 32'd0);
    ia.start_signal = 1'b1;
    step(2);
    chk("clamp_tick", time_a(), tv(15, 59, 59, 998));
    ia.start_signal = 1'b0;
    step(1);
    chk("stop_no_dec", time_a(), tv(15, 59, 59, 998));
    chk("stop_idle", flags_a(), 32'd0);

    // zero start
    load_a(0, 0, 0, 0);
    ia.start_signal = 1'b1;
    step(1);
    chk("zero_start", flags_a(), 32'd3);
    step(1);
    chk("zero_start_done", flags_a(), 32'd2);
    ia.start_signal = 1'b0;

    // load on the final-tick cycle
    load_a(0, 0, 0, 2);
    ia.start_signal = 1'b1;
    step(2);
    chk("final_pre", time_a(), tv(0, 0, 0, 1));
    load_a(0, 0, 5, 0);
    chk("final_load_val", time_a(), tv(0, 0, 5, 0));
    chk("final_load_flags", flags_a(), 32'd0);
    step(1);
    chk("final_restart", flags_a(), 32'd4);
    chk("final_restart_val", time_a(), tv(0, 0, 5, 0));
    ia.start_signal = 1'b0;

    // pause with TICK_DIV=4
    ib.load_seconds = 6'd10; ib.load = 1'b1;
    step(1);
    ib.load = 1'b0;
    chk("pause_load", time_b(), tv(0, 0, 10, 0));
    ib.start_signal = 1'b1;
    step(1);
    chk("pause_running", {31'd0, ib.running}, 32'd1);
    step(10);
    chk("pause_2ticks", time_b(), tv(0, 0, 9, 998));
    ib.start_signal = 1'b0;
    step(1);
    chk("pause_idle", {31'd0, ib.running}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(500);
      chk("pause_frozen", time_b(), tv(0, 0, 9, 998));
    end
    ib.start_signal = 1'b1;
    step(1);
    chk("resume_run", time_b(), tv(0, 0, 9, 998));
    step(1);
    chk("resume_partial", time_b(), tv(0, 0, 9, 998));
    step(1);
    chk("resume_tick", time_b(), tv(0, 0, 9, 997));
    ib.start_signal = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
